// File: rtl/ram_pkg.sv
// ram_pkg: shared FSM encoding, width defaults and port-select constants
// for the two-port RAM arbiter.
`default_nettype none

package ram_pkg;

  localparam int RAM_ADDR_W = 21;
  localparam int RAM_DATA_W = 8;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

`default_nettype wire

// File: rtl/ram_rr_grant.sv
// ram_rr_grant: two-way round-robin pick with its last_grant register.
`default_nettype none

module ram_rr_grant
  import ram_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req_a,
  input  logic req_b,
  input  logic take,
  output logic pick_valid,
  output logic pick,
  output logic last_grant
);

  always_comb begin
    pick_valid = req_a | req_b;
    pick       = PORT_A;
    // On contention, favour the port that was not served last.
    if (req_a && req_b) begin
      pick = ~last_grant;
    end else if (req_b) begin
      pick = PORT_B;
    end
  end

  // Resetting to B makes the first contended grant go to A.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= PORT_B;
    end else if (take) begin
      last_grant <= pick;
    end
  end

endmodule

`default_nettype wire

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one memory channel between stallable port A and
// acknowledged port B, one transaction in flight, round-robin grant.
`default_nettype none

module ram_port_arbiter
  import ram_pkg::*;
#(
  parameter int ADDR_W = RAM_ADDR_W,
  parameter int DATA_W = RAM_DATA_W
) (
  input  logic              clk_peripheral,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_ack,
  output logic              wait_a_n,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_ack,
  output logic              mem_valid,
  input  logic              mem_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t state;
  state_t state_next;
  logic   pick_valid;
  logic   pick;
  logic   last_grant;
  logic   take;
  logic   rd_latch;
  logic   ack_set;

  // last_grant doubles as the owner of the in-flight transaction.
  ram_rr_grant u_grant (
    .clk        (clk_peripheral),
    .reset      (reset),
    .req_a      (a_req),
    .req_b      (b_req),
    .take       (take),
    .pick_valid (pick_valid),
    .pick       (pick),
    .last_grant (last_grant)
  );

  always_ff @(posedge clk_peripheral) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    take       = 1'b0;
    rd_latch   = 1'b0;
    ack_set    = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          take       = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_ready) begin
          state_next = mem_we ? DONE : RDWAIT;
        end
      end
      RDWAIT: begin
        // Read data returning in any other state is stale and dropped here.
        if (mem_rvalid) begin
          rd_latch   = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        ack_set    = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_peripheral) begin
    if (reset) begin
      mem_valid <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      a_rdata   <= '0;
      b_rdata   <= '0;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      wait_a_n  <= 1'b1;
    end else begin
      a_ack <= 1'b0;
      b_ack <= 1'b0;

      if (take) begin
        mem_valid <= 1'b1;
        mem_we    <= (pick == PORT_B) ? b_we    : a_we;
        mem_addr  <= (pick == PORT_B) ? b_addr  : a_addr;
        mem_wdata <= (pick == PORT_B) ? b_wdata : a_wdata;
      end else if (state == ISSUE && mem_ready) begin
        mem_valid <= 1'b0;
      end

      if (rd_latch) begin
        if (last_grant == PORT_B) begin
          b_rdata <= mem_rdata;
        end else begin
          a_rdata <= mem_rdata;
        end
      end

      if (ack_set) begin
        if (last_grant == PORT_B) begin
          b_ack <= 1'b1;
        end else begin
          a_ack <= 1'b1;
        end
      end

      // Stall A while its request is pending or its transaction is in flight.
      if (ack_set && last_grant == PORT_A) begin
        wait_a_n <= 1'b1;
      end else if (a_req || (state != IDLE && last_grant == PORT_A)) begin
        wait_a_n <= 1'b0;
      end else begin
        wait_a_n <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire
